score_bcd_decoder: RTL and testbench
====================================

Name: score_bcd_decoder

Overview:
- Reader side of the score counter: takes the 32-bit binary score and converts it to packed BCD digits for the VGA score text renderer.
- Sequential double-dabble, one shift per clock; re-converts automatically whenever the score value changes.
- Drives stable digits, leading-zero blank mask and overflow flag to the HUD glyph lookup; outputs change only on a commit cycle.

Parameters:
- NUM_DIGITS, 6, number of decimal digits presented (1..10)
- SCORE_W, 32, width of binary score input

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- score  in  SCORE_W  binary score from score counter
- digits  out  4*NUM_DIGITS  packed BCD, digit 0 (units) in bits [3:0]
- blank  out  NUM_DIGITS  1 = leading zero, renderer suppresses glyph; bit 0 always 0
- overflow  out  1  score >= 10^NUM_DIGITS; digits forced to all 9s
- valid  out  1  digits reflect a completed conversion (sticky after first commit)
- busy  out  1  conversion in progress

Behaviour:
- Reset (Reset_n low, async): state IDLE; digits = 0; blank = all 1s except bit 0 = 0; overflow = 0; valid = 0; busy = 0; last_score = 0; shift register and counter cleared.
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
- IDLE: if (score != last_score) or (valid == 0) -> LOAD next cycle; else stay. busy = 0.
- LOAD (1 cycle): capture score into shift register and into last_score; clear 40-bit BCD accumulator (10 digits, always full width internally); shift counter = 0; compute overflow_next = (captured >= 10^NUM_DIGITS) against constant from package. busy = 1.
- SHIFT (SCORE_W cycles): each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1; counter increments; exit to COMMIT when counter == SCORE_W-1 after its shift. busy = 1.
- COMMIT (1 cycle): digits <= low NUM_DIGITS nibbles (or all 4'h9 if overflow_next); overflow <= overflow_next; blank computed from most significant digit downward: bit i = 1 iff all digits i..NUM_DIGITS-1 are zero and i != 0 (overflow case: blank = 0); valid <= 1; -> IDLE. busy = 1 in COMMIT.
- Latency: score change seen in IDLE cycle t -> LOAD t+1 -> SHIFT t+2..t+SCORE_W+1 -> outputs updated at edge ending COMMIT, visible cycle t+SCORE_W+3 (35 cycles for SCORE_W=32).
- Score changes during LOAD/SHIFT/COMMIT are ignored; on return to IDLE the compare against last_score picks up the newest value (intermediate values may be skipped; no queueing).
- Outputs glitch-free: digits/blank/overflow change only in COMMIT.
- Reset mid-conversion: abandons immediately, outputs to reset values, valid = 0; first conversion after release (score 0 included) forced by valid == 0.
- Width rules: nibble add-3 is 4-bit, no carry across nibbles; accumulator fixed 40 bits (covers 2^32-1 = 4294967295).

Decomposition:
- Package score_pkg: typedef enum for FSM states; constant BCD_DIGITS_MAX = 10; function/constant table POW10[0:10] (64-bit) for overflow threshold; typedef for bcd digit (logic [3:0]).
- One natural sub-module: bcd_add3_nibble (combinational, >=5 ? +3 : pass), instantiated 10 times in a generate loop.

Test Plan:
- Reset release with score = 0 -> after 35 cycles valid = 1, digits = 0x000000, blank = 6'b111110, overflow = 0.
- score stepped 0 -> 50 -> busy high 34 cycles, then digits = 0x000050, blank = 6'b111100.
- score = 999999 -> digits = 0x999999, blank = 0, overflow = 0; then score = 1000000 -> digits = 0x999999, overflow = 1, blank = 0.
- score changes 100 -> 150 -> 200 while busy (cycles 5 and 10 of SHIFT) -> one conversion completes with 100, a second starts immediately and completes with 200; 150 never presented.
- NUM_DIGITS = 10, score = 32'hFFFFFFFF -> digits = 40'h4294967295, overflow = 0.
- Reset_n pulsed low during SHIFT cycle 12 -> outputs return to reset values asynchronously, valid = 0; after release, fresh conversion of current score completes in 35 cycles.

Source files
------------

// File: rtl/score_bcd_decoder_pkg.sv
// Shared types and constants for the score binary-to-BCD reader.
// BCD accumulator is always 10 digits wide, enough for any 32-bit score.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned BCD_DIGITS_MAX = 10;
  localparam int unsigned BCD_W          = 4 * BCD_DIGITS_MAX;

  // 10^n in 64 bits; 10^10 is needed as the NUM_DIGITS=10 overflow threshold.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/score_bcd_decoder_if.sv
// Score-in / digits-out bundle between the score counter, decoder and HUD.
interface score_bcd_decoder_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCORE_W    = 32
);

  logic [SCORE_W-1:0]      score;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    overflow;
  logic                    valid;
  logic                    busy;

  modport master (
    output score,
    input  digits, blank, overflow, valid, busy
  );

  modport slave (
    input  score,
    output digits, blank, overflow, valid, busy
  );

endinterface

// File: rtl/score_bcd_decoder_add3.sv
// Double-dabble correction step for one BCD nibble: values >= 5 get +3.
module bcd_add3_nibble
  import score_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  always_comb begin
    dout = (din >= 4'd5) ? bcd_digit_t'(din + 4'd3) : din;
  end

endmodule

// File: rtl/score_bcd_decoder.sv
// Sequential double-dabble score converter; outputs only move on COMMIT,
// so the HUD glyph lookup never sees a half-converted value.
module score_bcd_decoder
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCORE_W    = 32
) (
  input  logic                Clk,
  input  logic                Reset_n,
  score_bcd_decoder_if.slave  bus
);

  localparam int unsigned           CNT_W     = $clog2(SCORE_W) + 1;
  localparam logic [63:0]           OVF_LIMIT = pow10(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      LAST_SHIFT = CNT_W'(SCORE_W - 1);
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~(NUM_DIGITS'(1));

  state_t                  state;
  logic [SCORE_W-1:0]      last_score;
  logic [SCORE_W-1:0]      bin_sr;
  logic [BCD_W-1:0]        bcd_sr;
  logic [BCD_W-1:0]        bcd_adj;
  logic [CNT_W-1:0]        shift_cnt;
  logic                    overflow_next;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    overflow_q;
  logic                    valid_q;
  logic                    busy_q;

  logic [4*NUM_DIGITS-1:0] digits_next;
  logic [NUM_DIGITS-1:0]   blank_next;

  for (genvar g = 0; g < BCD_DIGITS_MAX; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .din  (bcd_sr[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Presented values, derived from the finished accumulator.
  always_comb begin
    logic        zero_run;
    int unsigned idx;
    digits_next = '0;
    blank_next  = '0;
    zero_run    = 1'b1;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      digits_next[4*k +: 4] = overflow_next ? 4'h9 : bcd_sr[4*k +: 4];
    end
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx      = NUM_DIGITS - 1 - k;
      zero_run = zero_run && (bcd_sr[4*idx +: 4] == 4'h0);
      blank_next[idx] = zero_run && (idx != 0) && !overflow_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      last_score    <= '0;
      bin_sr        <= '0;
      bcd_sr        <= '0;
      shift_cnt     <= '0;
      overflow_next <= 1'b0;
      digits_q      <= '0;
      blank_q       <= BLANK_RST;
      overflow_q    <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((bus.score != last_score) || !valid_q) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          bin_sr        <= bus.score;
          last_score    <= bus.score;
          bcd_sr        <= '0;
          shift_cnt     <= '0;
          overflow_next <= (64'(bus.score) >= OVF_LIMIT);
          state         <= SHIFT;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
          shift_cnt        <= shift_cnt + CNT_W'(1);
          if (shift_cnt == LAST_SHIFT) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          digits_q   <= digits_next;
          blank_q    <= blank_next;
          overflow_q <= overflow_next;
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.digits   = digits_q;
  assign bus.blank    = blank_q;
  assign bus.overflow = overflow_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_score_bcd_decoder.sv
// Scoreboard bench: a 6-digit and a 10-digit decoder share one score stream;
// expectations come from a decimal arithmetic model, checked on each commit.
module tb_score_bcd_decoder;

  typedef struct {
    logic [31:0] s;
    int unsigned launch;
  } exp_t;

  logic        Clk;
  logic        Reset_n;
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;
  exp_t        q6[$];
  exp_t        q10[$];
  logic [31:0] cur;

  score_bcd_decoder_if #(.NUM_DIGITS(6),  .SCORE_W(32)) bus6  ();
  score_bcd_decoder_if #(.NUM_DIGITS(10), .SCORE_W(32)) bus10 ();

  score_bcd_decoder #(.NUM_DIGITS(6), .SCORE_W(32)) dut6 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus6.slave)
  );

  score_bcd_decoder #(.NUM_DIGITS(10), .SCORE_W(32)) dut10 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus10.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal reference: digits by repeated division, blank where score < 10^i.
  function automatic void model(input int unsigned nd, input logic [31:0] s,
                                output logic [39:0] dg, output logic [9:0] bl,
                                output logic ov);
    longint unsigned v;
    longint unsigned lim;
    longint unsigned p;
    v   = longint'(s);
    lim = 1;
    for (int unsigned k = 0; k < nd; k++) lim = lim * 10;
    ov = (v >= lim);
    dg = '0;
    bl = '0;
    for (int unsigned i = 0; i < nd; i++) begin
      dg[4*i +: 4] = ov ? 4'h9 : 4'(v % 10);
      v = v / 10;
    end
    p = 1;
    for (int unsigned i = 1; i < nd; i++) begin
      p = p * 10;
      bl[i] = !ov && (longint'(s) < p);
    end
  endfunction

  task automatic check_commit(input string tag, input int unsigned nd, input exp_t e,
                              input logic [39:0] dact, input logic [9:0] bact,
                              input logic ovact, input logic vact);
    logic [39:0] dg;
    logic [9:0]  bl;
    logic        ov;
    model(nd, e.s, dg, bl, ov);
    chk({tag, "_digits"},   dact, dg);
    chk({tag, "_blank"},    bact, bl);
    chk({tag, "_overflow"}, ovact, ov);
    chk({tag, "_valid"},    vact, 1'b1);
    chk({tag, "_latency"},  cyc - e.launch, 35);
  endtask

  // Monitors: a falling busy marks a commit; the outputs are checked then.
  logic        pb6, pb10;
  int unsigned run6, run10;
  initial begin
    pb6 = 0; pb10 = 0; run6 = 0; run10 = 0;
  end

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      pb6 = 0; run6 = 0;
    end else begin
      if (bus6.busy) run6++;
      if (pb6 && !bus6.busy) begin
        chk("busy_len6", run6, 34);
        run6 = 0;
        chk("pending6", q6.size() != 0, 1'b1);
        if (q6.size() != 0) begin
          e = q6.pop_front();
          check_commit("d6", 6, e, 40'(bus6.digits), 10'(bus6.blank), bus6.overflow, bus6.valid);
        end
      end
      pb6 = bus6.busy;
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      pb10 = 0; run10 = 0;
    end else begin
      if (bus10.busy) run10++;
      if (pb10 && !bus10.busy) begin
        chk("busy_len10", run10, 34);
        run10 = 0;
        chk("pending10", q10.size() != 0, 1'b1);
        if (q10.size() != 0) begin
          e = q10.pop_front();
          check_commit("d10", 10, e, bus10.digits, bus10.blank, bus10.overflow, bus10.valid);
        end
      end
      pb10 = bus10.busy;
    end
  end

  task automatic push_exp(input logic [31:0] s, input int unsigned launch);
    exp_t e;
    e.s = s;
    e.launch = launch;
    q6.push_back(e);
    q10.push_back(e);
  endtask

  task automatic set_score(input logic [31:0] v);
    bus6.score  = v;
    bus10.score = v;
    cur         = v;
  endtask

  task automatic launch(input logic [31:0] v);
    @(negedge Clk);
    set_score(v);
    push_exp(v, cyc);
  endtask

  task automatic wait_idle();
    bool_done: begin
      for (int unsigned n = 0; n < 300; n++) begin
        @(negedge Clk);
        if (q6.size() == 0 && q10.size() == 0) disable bool_done;
      end
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout with %0d/%0d commits pending", q6.size(), q10.size());
      q6.delete();
      q10.delete();
    end
    repeat (3) @(negedge Clk);
    chk("idle6_busy",  bus6.busy,  1'b0);
    chk("idle10_busy", bus10.busy, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_digits6"},   bus6.digits,    '0);
    chk({tag, "_blank6"},    bus6.blank,     6'b111110);
    chk({tag, "_ovf6"},      bus6.overflow,  1'b0);
    chk({tag, "_valid6"},    bus6.valid,     1'b0);
    chk({tag, "_busy6"},     bus6.busy,      1'b0);
    chk({tag, "_digits10"},  bus10.digits,   '0);
    chk({tag, "_blank10"},   bus10.blank,    10'h3FE);
    chk({tag, "_valid10"},   bus10.valid,    1'b0);
  endtask

  initial begin
    logic [31:0]     v;
    longint unsigned p;
    int unsigned     l;
    checks  = 0;
    errors  = 0;
    Reset_n = 1'b0;
    set_score(32'd0);
    repeat (3) @(negedge Clk);
    check_reset("por");

    // First conversion forced by valid==0 even though score equals last_score.
    Reset_n = 1'b1;
    push_exp(32'd0, cyc);
    wait_idle();

    launch(32'd50);       wait_idle();
    launch(32'd999999);   wait_idle();
    launch(32'd1000000);  wait_idle();

    // Changes while busy: 150 is never presented, 200 follows immediately.
    launch(32'd100);
    l = cyc;
    repeat (7) @(negedge Clk);
    set_score(32'd150);
    repeat (5) @(negedge Clk);
    set_score(32'd200);
    push_exp(32'd200, l + 35);
    wait_idle();

    launch(32'hFFFF_FFFF); wait_idle();

    for (int unsigned n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom_range(0, 999999);
        2: v = $urandom_range(0, 120);
        default: begin
          p = 1;
          for (int unsigned k = 0; k < $urandom_range(1, 9); k++) p = p * 10;
          v = 32'(p - 1 + longint'($urandom_range(0, 2)));
        end
      endcase
      if (v != cur) begin
        launch(v);
        wait_idle();
      end
    end

    // Reset in the middle of SHIFT abandons the conversion.
    @(negedge Clk);
    set_score(32'd4321);
    repeat (14) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_reset("mid");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    push_exp(32'd4321, cyc);
    wait_idle();

    // Idle reset with score 0: valid==0 still forces a conversion.
    launch(32'd0);
    wait_idle();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1 check_reset("idle");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    push_exp(32'd0, cyc);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
